// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared widths, state encoding and parity helper for the parity arbiter
package parity_pkg;
  localparam int DATA_W  = 8;
  localparam int FRAME_W = 9;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Bit that makes the XOR of {bit, byte} equal to zero.
  function automatic logic parity_even(input logic [DATA_W-1:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/parity_generator.sv
// rtl/parity_generator.sv - byte to {even parity, byte} frame
module parity_generator
  import parity_pkg::*;
(
  input  logic [DATA_W-1:0]  data,
  output logic [FRAME_W-1:0] frame
);
  assign frame = {parity_even(data), data};
endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: rotate by ptr, lowest-set find, unrotate
module rr_pick #(
  parameter  int N   = 4,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx
);
  logic [N-1:0]   rot;
  logic [IDW-1:0] k_idx;
  logic [IDW:0]   sum;

  always_comb begin
    rot   = '0;
    k_idx = '0;
    sum   = '0;
    grant = '0;
    idx   = '0;
    // rot[k] is the requester k positions after ptr
    for (int k = 0; k < N; k++) begin
      rot[k] = req[(int'(ptr) + k) % N];
    end
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) k_idx = IDW'(k);
    end
    sum = {1'b0, ptr} + {1'b0, k_idx};
    if (sum >= (IDW+1)'(N)) sum = sum - (IDW+1)'(N);
    idx = sum[IDW-1:0];
    if (|rot) grant[idx] = 1'b1;
  end
endmodule

// File: rtl/parity_share_arbiter.sv
// rtl/parity_share_arbiter.sv - round-robin sharing of one parity generator with a registered output stage
module parity_share_arbiter
  import parity_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  bit ODD_PARITY = 1'b0,
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [FRAME_W-1:0]        out_data,
  output logic [IDW-1:0]            out_id,
  output logic                      busy
);
  state_t             state, state_nxt;
  logic [IDW-1:0]     rr_ptr;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDW-1:0]     pick_idx;
  logic               can_load;
  logic               accept;
  logic [DATA_W-1:0]  sel_byte;
  logic [FRAME_W-1:0] pg_frame;
  logic [FRAME_W-1:0] load_frame;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign sel_byte = req_data[int'(pick_idx)*DATA_W +: DATA_W];

  parity_generator u_pg (
    .data  (sel_byte),
    .frame (pg_frame)
  );

  assign load_frame = {pg_frame[FRAME_W-1] ^ ODD_PARITY, pg_frame[DATA_W-1:0]};

  // Grants are masked while reset is held so no handshake completes then.
  assign can_load  = !rst && ((state == ST_EMPTY) || out_ready);
  assign req_ready = can_load ? pick_grant : '0;
  assign accept    = |req_ready;
  assign out_valid = (state == ST_FULL);
  assign busy      = out_valid;

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = ST_FULL;
    end else if (state == ST_FULL && out_ready) begin
      state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_EMPTY;
      out_data <= '0;
      out_id   <= '0;
      rr_ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        out_data <= load_frame;
        out_id   <= pick_idx;
        rr_ptr   <= (pick_idx == IDW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_parity_share_arbiter.sv
// tb/tb_parity_share_arbiter.sv - randomized and directed checks of parity_share_arbiter against a queue-free reference model
module tb_parity_share_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data  = '0;
  logic           out_ready = 1'b0;

  logic [N-1:0]   req_ready_e, req_ready_o;
  logic           out_valid_e, out_valid_o, busy_e, busy_o;
  logic [8:0]     out_data_e, out_data_o;
  logic [IDW-1:0] out_id_e, out_id_o;

  always #5 clk = ~clk;

  parity_share_arbiter #(.NUM_REQ(N), .ODD_PARITY(1'b0)) dut_even (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready_e), .out_valid(out_valid_e), .out_ready(out_ready),
    .out_data(out_data_e), .out_id(out_id_e), .busy(busy_e)
  );

  parity_share_arbiter #(.NUM_REQ(N), .ODD_PARITY(1'b1)) dut_odd (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready_o), .out_valid(out_valid_o), .out_ready(out_ready),
    .out_data(out_data_o), .out_id(out_id_o), .busy(busy_o)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         m_ptr;
  bit         m_valid;
  logic [8:0] m_data, m_odd;
  int         m_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int popcount_parity(input logic [7:0] b);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(b[i]);
    return c % 2;
  endfunction

  // Winner under the current inputs, or -1 when nothing can be accepted.
  function automatic int model_grant();
    if (m_valid && !out_ready) return -1;
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_data = '0; m_odd = '0; m_id = 0;
  endtask

  task automatic model_step();
    int g = model_grant();
    if (g >= 0) begin
      logic [7:0] b = req_data[8*g +: 8];
      int p = popcount_parity(b);
      m_data  = {p[0], b};
      m_odd   = {~p[0], b};
      m_id    = g;
      m_valid = 1;
      m_ptr   = (g + 1) % N;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic check_ready();
    int g = model_grant();
    logic [N-1:0] exp = (g < 0) ? '0 : N'(1) << g;
    chk("req_ready_even", 32'(req_ready_e), 32'(exp));
    chk("req_ready_odd", 32'(req_ready_o), 32'(exp));
  endtask

  task automatic check_out();
    chk("out_valid", 32'(out_valid_e), 32'(m_valid));
    chk("busy", 32'(busy_e), 32'(m_valid));
    chk("out_data_even", 32'(out_data_e), 32'(m_data));
    chk("out_id", 32'(out_id_e), 32'(m_id));
    chk("out_valid_odd", 32'(out_valid_o), 32'(m_valid));
    chk("out_data_odd", 32'(out_data_o), 32'(m_odd));
    chk("out_id_odd", 32'(out_id_o), 32'(m_id));
  endtask

  task automatic cyc(input logic [N-1:0] v, input logic [8*N-1:0] d, input logic r);
    req_valid = v; req_data = d; out_ready = r;
    #1 check_ready();
    @(posedge clk);
    model_step();
    #1 check_out();
  endtask

  logic [8:0] rr_par [4] = '{9'h100, 9'h000, 9'h100, 9'h000};

  initial begin
    model_reset();
    // reset held with every requester asking
    req_valid = 4'b1111;
    #3;
    chk("rst_ready", 32'(req_ready_e), 0);
    chk("rst_valid", 32'(out_valid_e), 0);
    chk("rst_data", 32'(out_data_e), 0);
    chk("rst_id", 32'(out_id_e), 0);
    @(posedge clk); #1 rst = 1'b0;
    cyc(4'b1111, 32'h0, 1'b1);
    chk("t1_id", 32'(out_id_e), 0);
    chk("t1_data", 32'(out_data_e), 32'h000);
    cyc(4'b0000, 32'h0, 1'b1);

    cyc(4'b0100, 32'h0007_0000, 1'b1);
    chk("t2_valid", 32'(out_valid_e), 1);
    chk("t2_data", 32'(out_data_e), 32'h107);
    chk("t2_id", 32'(out_id_e), 2);

    cyc(4'b1000, 32'h5500_0000, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc(4'b1111, 32'h0F07_0301, 1'b1);
      chk("t3_id", 32'(out_id_e), 32'(i % 4));
      chk("t3_par", 32'(out_data_e & 9'h100), 32'(rr_par[i % 4]));
    end

    for (int i = 0; i < 5; i++) begin
      cyc(4'b1111, 32'h0F07_0301, 1'b0);
      chk("t4_ready", 32'(req_ready_e), 0);
      chk("t4_data", 32'(out_data_e), 32'h00F);
      chk("t4_id", 32'(out_id_e), 3);
    end
    req_valid = 4'b1111; out_ready = 1'b1;
    #1 chk("t4_regrant", 32'(req_ready_e), 32'b0001);
    cyc(4'b1111, 32'h0F07_0301, 1'b1);
    chk("t4_next_id", 32'(out_id_e), 0);
    chk("t4_next_data", 32'(out_data_e), 32'h101);

    cyc(4'b0010, 32'h0000_FF00, 1'b1);
    chk("t5_odd_ff", 32'(out_data_o), 32'h1FF);
    chk("t5_even_ff", 32'(out_data_e), 32'h0FF);
    cyc(4'b0100, 32'h0001_0000, 1'b1);
    chk("t5_odd_01", 32'(out_data_o), 32'h001);

    cyc(4'b0000, 32'h0, 1'b0);
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_valid_drop", 32'(out_valid_e), 0);
    chk("t6_ready", 32'(req_ready_e), 0);
    @(posedge clk); #1 check_out();
    rst = 1'b0;
    cyc(4'b1001, 32'hAA00_0055, 1'b1);
    chk("t6_id", 32'(out_id_e), 0);

    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] v = N'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) v = N'(1) << $urandom_range(0, N - 1);
      cyc(v, 32'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
